// File: rtl/ysyx_25030085_lsu_pkg.sv
// Shared definitions for the load/store unit: memory-op codes, FSM encoding
// and the command legality/alignment checks.
package ysyx_25030085_lsu_pkg;

    localparam logic [2:0] MEMOP_B  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_W  = 3'b010;
    localparam logic [2:0] MEMOP_BU = 3'b100;
    localparam logic [2:0] MEMOP_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    // Unsigned variants only make sense for loads.
    function automatic logic legal_op(input logic [2:0] op, input logic we);
        logic ok;
        case (op)
            MEMOP_B, MEMOP_H, MEMOP_W: ok = 1'b1;
            MEMOP_BU, MEMOP_HU:        ok = ~we;
            default:                   ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic aligned(input logic [2:0] op, input logic [1:0] k);
        logic ok;
        case (op)
            MEMOP_H, MEMOP_HU: ok = ~k[0];
            MEMOP_W:           ok = (k == 2'b00);
            default:           ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ysyx_25030085_lsu_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
// Purely combinational; k is the byte offset inside the 32-bit word.
module ysyx_25030085_lsu_align
    import ysyx_25030085_lsu_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [1:0]  k_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted_s;

    assign shifted_s = rdata_i >> {k_i, 3'b000};

    always_comb begin
        wstrb_o = 4'b0000;
        wdata_o = 32'h0000_0000;
        rdata_o = 32'h0000_0000;
        case (op_i)
            MEMOP_B: begin
                wstrb_o = 4'b0001 << k_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
            end
            MEMOP_BU: begin
                wstrb_o = 4'b0001 << k_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {24'h00_0000, shifted_s[7:0]};
            end
            MEMOP_H: begin
                wstrb_o = 4'b0011 << k_i;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
            end
            MEMOP_HU: begin
                wstrb_o = 4'b0011 << k_i;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {16'h0000, shifted_s[15:0]};
            end
            MEMOP_W: begin
                wstrb_o = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = rdata_i;
            end
            default: begin
                wstrb_o = 4'b0000;
                wdata_o = 32'h0000_0000;
                rdata_o = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_25030085_lsu.sv
// Load/store unit FSM bridging core memory commands to a valid/ready bus.
// Optional response timeout is enabled by defining LSU_TIMEOUT_EN.
module ysyx_25030085_lsu
    import ysyx_25030085_lsu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        mem_op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              err,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic [ADDR_W-1:0] bus_req_addr,
    output logic              bus_req_we,
    output logic [3:0]        bus_req_wstrb,
    output logic [31:0]       bus_req_wdata,
    input  logic              bus_rsp_valid,
    output logic              bus_rsp_ready,
    input  logic [31:0]       bus_rsp_rdata,
    input  logic              bus_rsp_err
);

    lsu_state_e        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        op_q;
    logic [31:0]       wdata_q;
    logic              we_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [31:0]       rdata_q;
    logic              req_valid_q;
    logic              rsp_ready_q;

    logic [3:0]        strb_s;
    logic [31:0]       steer_wdata_s;
    logic [31:0]       ext_rdata_s;
    logic              cmd_ok_s;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    logic [CNT_W-1:0]  cnt_q;
`endif

    ysyx_25030085_lsu_align u_align (
        .op_i    (op_q),
        .k_i     (addr_q[1:0]),
        .wdata_i (wdata_q),
        .rdata_i (bus_rsp_rdata),
        .wstrb_o (strb_s),
        .wdata_o (steer_wdata_s),
        .rdata_o (ext_rdata_s)
    );

    assign cmd_ok_s = ~(mem_read & mem_write)
                    & legal_op(mem_op, mem_write)
                    & aligned(mem_op, addr[1:0]);

    // Request fields come straight from captured registers so they hold until accepted.
    assign bus_req_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus_req_we    = we_q;
    assign bus_req_wstrb = we_q ? strb_s : 4'b0000;
    assign bus_req_wdata = steer_wdata_s;
    assign bus_req_valid = req_valid_q;
    assign bus_rsp_ready = rsp_ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign rdata         = rdata_q;

    // Main command FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            op_q        <= 3'b000;
            wdata_q     <= 32'h0000_0000;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 32'h0000_0000;
            req_valid_q <= 1'b0;
            rsp_ready_q <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (core_valid && (mem_read || mem_write)) begin
                        addr_q  <= addr;
                        op_q    <= mem_op;
                        wdata_q <= wdata;
                        we_q    <= mem_write;
                        busy_q  <= 1'b1;
                        if (cmd_ok_s) begin
                            req_valid_q <= 1'b1;
                            state_q     <= ST_REQ;
                        end else begin
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= 32'h0000_0000;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus_req_ready) begin
                        req_valid_q <= 1'b0;
                        rsp_ready_q <= 1'b1;
                        state_q     <= ST_RSP;
`ifdef LSU_TIMEOUT_EN
                        cnt_q       <= '0;
`endif
                    end
                end
                ST_RSP: begin
                    if (bus_rsp_valid) begin
                        rsp_ready_q <= 1'b0;
                        done_q      <= 1'b1;
                        err_q       <= bus_rsp_err;
                        rdata_q     <= we_q ? 32'h0000_0000 : ext_rdata_s;
                        state_q     <= ST_DONE;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        rsp_ready_q <= 1'b0;
                        done_q      <= 1'b1;
                        err_q       <= 1'b1;
                        rdata_q     <= 32'h0000_0000;
                        state_q     <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
`endif
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= 32'h0000_0000;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    err_q       <= 1'b0;
                    req_valid_q <= 1'b0;
                    rsp_ready_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25030085_lsu.sv
// Self-checking bench for ysyx_25030085_lsu: vector table with a scoreboard
// queue, plus directed reset, ignored-command and timeout sequences.
module tb_ysyx_25030085_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_valid, mem_read, mem_write;
    logic [2:0]  mem_op;
    logic [31:0] addr, wdata;
    logic        busy, done, err;
    logic [31:0] rdata;
    logic        bus_req_valid, bus_req_ready, bus_req_we;
    logic [31:0] bus_req_addr, bus_req_wdata;
    logic [3:0]  bus_req_wstrb;
    logic        bus_rsp_valid, bus_rsp_ready, bus_rsp_err;
    logic [31:0] bus_rsp_rdata;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    ysyx_25030085_lsu #(.ADDR_W(32), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n), .core_valid(core_valid), .mem_read(mem_read),
        .mem_write(mem_write), .mem_op(mem_op), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata), .err(err),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_req_addr(bus_req_addr), .bus_req_we(bus_req_we),
        .bus_req_wstrb(bus_req_wstrb), .bus_req_wdata(bus_req_wdata),
        .bus_rsp_valid(bus_rsp_valid), .bus_rsp_ready(bus_rsp_ready),
        .bus_rsp_rdata(bus_rsp_rdata), .bus_rsp_err(bus_rsp_err)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rsp_data;
        logic        rsp_err;
        int          req_dly;
        int          rsp_dly;
        logic        exp_bus;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[16];
    vec_t sb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    task automatic idle_inputs();
        core_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        mem_op = 3'b000; addr = 32'h0; wdata = 32'h0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        vec_t        e;
        logic [31:0] f_addr, f_wd;
        logic [3:0]  f_strb;
        logic        f_we;
        bit          seen, stable, clean, got;
        int          req_w, rsp_w, lat, exp_lat;
        string       tag;
        tag = $sformatf("v%0d", idx);
        seen = 0; stable = 1; clean = 1; got = 0; req_w = 0; rsp_w = 0; lat = 0;
        f_addr = 32'h0; f_wd = 32'h0; f_strb = 4'h0; f_we = 1'b0;
        @(negedge clk);
        core_valid = 1'b1; mem_read = v.rd; mem_write = v.wr;
        mem_op = v.op; addr = v.addr; wdata = v.wdata;
        sb_q.push_back(v);
        for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
            @(negedge clk);
            if (bus_req_valid) begin
                if (!seen) begin
                    seen = 1; f_addr = bus_req_addr; f_strb = bus_req_wstrb;
                    f_wd = bus_req_wdata; f_we = bus_req_we;
                end else if (f_addr !== bus_req_addr || f_strb !== bus_req_wstrb ||
                             f_wd !== bus_req_wdata || f_we !== bus_req_we) begin
                    stable = 0;
                end
                if (req_w >= v.req_dly) bus_req_ready = 1'b1;
                else begin bus_req_ready = 1'b0; req_w++; end
            end else begin
                bus_req_ready = 1'b0;
            end
            if (bus_rsp_ready) begin
                if (rsp_w >= v.rsp_dly) begin
                    bus_rsp_valid = 1'b1; bus_rsp_rdata = v.rsp_data; bus_rsp_err = v.rsp_err;
                end else begin
                    bus_rsp_valid = 1'b0; rsp_w++;
                end
            end else begin
                bus_rsp_valid = 1'b0;
            end
            if (done) begin
                got = 1; lat = cyc;
                idle_inputs();
                e = sb_q.pop_front();
                exp_lat = e.exp_bus ? (3 + e.req_dly + e.rsp_dly) : 1;
                chk({tag, "_err"}, {31'h0, err}, {31'h0, e.exp_err});
                chk({tag, "_rdata"}, rdata, e.exp_rdata);
                chk({tag, "_latency"}, lat, exp_lat);
            end else if (err !== 1'b0 || rdata !== 32'h0) begin
                clean = 0;
            end
        end
        if (!got) begin
            checks++;
            $display("FAIL %s_done_timeout: got no done within 40 cycles required done", tag);
            void'(sb_q.pop_front());
            idle_inputs();
        end
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
        chk({tag, "_bus_activity"}, {31'h0, seen}, {31'h0, v.exp_bus});
        if (v.exp_bus) begin
            chk({tag, "_req_addr"}, f_addr, {v.addr[31:2], 2'b00});
            chk({tag, "_req_we"}, {31'h0, f_we}, {31'h0, v.wr});
            chk({tag, "_wstrb"}, {28'h0, f_strb}, {28'h0, v.exp_wstrb});
            if (v.wr) chk({tag, "_wdata"}, f_wd, v.exp_wdata);
            chk({tag, "_req_stable"}, {31'h0, stable}, 32'h1);
        end
        chk({tag, "_quiet_when_not_done"}, {31'h0, clean}, 32'h1);
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] op,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rsp, input logic rerr,
                                input int rqd, input int rsd, input logic ebus,
                                input logic eerr, input logic [31:0] erd,
                                input logic [3:0] estrb, input logic [31:0] ewd);
        vec_t v;
        v.rd = rd; v.wr = wr; v.op = op; v.addr = a; v.wdata = wd;
        v.rsp_data = rsp; v.rsp_err = rerr; v.req_dly = rqd; v.rsp_dly = rsd;
        v.exp_bus = ebus; v.exp_err = eerr; v.exp_rdata = erd;
        v.exp_wstrb = estrb; v.exp_wdata = ewd;
        return v;
    endfunction

    initial begin
        int r_cyc, d_cyc;
        bit any_done;
        rst_n = 1'b0;
        idle_inputs();
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_rdata = 32'h0; bus_rsp_err = 1'b0;

        //          rd    wr    op      addr          wdata         rsp_data      rerr  rq rs bus   err   exp_rdata     strb     exp_wdata
        vecs[0]  = mk(1'b0, 1'b1, 3'b000, 32'h8000_0003, 32'h0000_00A5, 32'h0,        1'b0, 0, 0, 1'b1, 1'b0, 32'h0,        4'b1000, 32'hA5A5_A5A5);
        vecs[1]  = mk(1'b1, 1'b0, 3'b000, 32'h8000_0002, 32'h0,        32'h1280_FF34, 1'b0, 0, 0, 1'b1, 1'b0, 32'hFFFF_FF80, 4'b0000, 32'h0);
        vecs[2]  = mk(1'b1, 1'b0, 3'b100, 32'h8000_0002, 32'h0,        32'h1280_FF34, 1'b0, 0, 0, 1'b1, 1'b0, 32'h0000_0080, 4'b0000, 32'h0);
        vecs[3]  = mk(1'b1, 1'b0, 3'b001, 32'h8000_0001, 32'h0,        32'h0,        1'b0, 0, 0, 1'b0, 1'b1, 32'h0,        4'b0000, 32'h0);
        vecs[4]  = mk(1'b1, 1'b0, 3'b011, 32'h8000_0000, 32'h0,        32'h0,        1'b0, 0, 0, 1'b0, 1'b1, 32'h0,        4'b0000, 32'h0);
        vecs[5]  = mk(1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'h0,        32'hDEAD_BEEF, 1'b1, 5, 0, 1'b1, 1'b1, 32'hDEAD_BEEF, 4'b0000, 32'h0);
        vecs[6]  = mk(1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'h1234_ABCD, 32'h0,        1'b0, 1, 1, 1'b1, 1'b0, 32'h0,        4'b1100, 32'hABCD_ABCD);
        vecs[7]  = mk(1'b0, 1'b1, 3'b010, 32'h8000_0004, 32'hCAFE_F00D, 32'h0,        1'b0, 0, 2, 1'b1, 1'b0, 32'h0,        4'b1111, 32'hCAFE_F00D);
        vecs[8]  = mk(1'b1, 1'b0, 3'b001, 32'h8000_0002, 32'h0,        32'h8001_1234, 1'b0, 0, 0, 1'b1, 1'b0, 32'hFFFF_8001, 4'b0000, 32'h0);
        vecs[9]  = mk(1'b1, 1'b0, 3'b101, 32'h8000_0000, 32'h0,        32'h0000_9ABC, 1'b0, 2, 0, 1'b1, 1'b0, 32'h0000_9ABC, 4'b0000, 32'h0);
        vecs[10] = mk(1'b1, 1'b0, 3'b000, 32'h8000_0000, 32'h0,        32'h0000_007F, 1'b0, 0, 2, 1'b1, 1'b0, 32'h0000_007F, 4'b0000, 32'h0);
        vecs[11] = mk(1'b1, 1'b0, 3'b010, 32'h8000_0008, 32'h0,        32'h1234_5678, 1'b0, 0, 0, 1'b1, 1'b0, 32'h1234_5678, 4'b0000, 32'h0);
        vecs[12] = mk(1'b0, 1'b1, 3'b100, 32'h8000_0000, 32'h0000_0011, 32'h0,        1'b0, 0, 0, 1'b0, 1'b1, 32'h0,        4'b0000, 32'h0);
        vecs[13] = mk(1'b1, 1'b1, 3'b010, 32'h8000_0000, 32'h0,        32'h0,        1'b0, 0, 0, 1'b0, 1'b1, 32'h0,        4'b0000, 32'h0);
        vecs[14] = mk(1'b0, 1'b1, 3'b010, 32'h8000_0002, 32'h0,        32'h0,        1'b0, 0, 0, 1'b0, 1'b1, 32'h0,        4'b0000, 32'h0);
        vecs[15] = mk(1'b1, 1'b0, 3'b100, 32'h8000_0003, 32'h0,        32'hAB00_0000, 1'b0, 0, 0, 1'b1, 1'b0, 32'h0000_00AB, 4'b0000, 32'h0);

        #2;
        chk("reset_outputs",
            {busy, done, err, bus_req_valid, bus_req_we, bus_rsp_ready, bus_req_wstrb},
            32'h0);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_req_addr", bus_req_addr, 32'h0);
        chk("reset_req_wdata", bus_req_wdata, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

        // Command with neither read nor write must be ignored.
        @(negedge clk);
        core_valid = 1'b1; mem_op = 3'b010; addr = 32'h8000_0000;
        @(negedge clk);
        idle_inputs();
        any_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (busy || done || bus_req_valid) any_done = 1;
        end
        chk("nop_cmd_ignored", {31'h0, any_done}, 32'h0);

        // Asynchronous reset while waiting for a response.
        @(negedge clk);
        core_valid = 1'b1; mem_read = 1'b1; mem_op = 3'b010; addr = 32'h8000_0020;
        @(negedge clk);
        idle_inputs();
        bus_req_ready = 1'b1;
        @(negedge clk);
        bus_req_ready = 1'b0;
        chk("pre_reset_in_rsp", {31'h0, bus_rsp_ready}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("midop_reset_ctrl",
            {busy, done, err, bus_req_valid, bus_req_we, bus_rsp_ready, bus_req_wstrb},
            32'h0);
        chk("midop_reset_addr", bus_req_addr, 32'h0);
        chk("midop_reset_rdata", rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h5555_5555; bus_rsp_err = 1'b0;
        @(negedge clk);
        bus_rsp_valid = 1'b0;
        any_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (busy || done || rdata !== 32'h0) any_done = 1;
        end
        chk("late_rsp_ignored", {31'h0, any_done}, 32'h0);
        run_vec(vecs[11], 100);

        // Response never arrives.
        @(negedge clk);
        core_valid = 1'b1; mem_read = 1'b1; mem_op = 3'b010; addr = 32'h8000_0030;
        @(negedge clk);
        idle_inputs();
        bus_req_ready = 1'b1;
        r_cyc = -1; d_cyc = -1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            bus_req_ready = 1'b0;
            if (bus_rsp_ready && r_cyc < 0) r_cyc = cyc;
            if (done && d_cyc < 0) begin
                d_cyc = cyc;
                chk("timeout_err", {31'h0, err}, 32'h1);
                chk("timeout_rdata", rdata, 32'h0);
            end
        end
`ifdef LSU_TIMEOUT_EN
        chk("timeout_latency", d_cyc - r_cyc, 4);
`else
        chk("no_timeout_done", d_cyc, -1);
        chk("no_timeout_busy", {31'h0, busy}, 32'h1);
        #1 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`endif
        run_vec(vecs[0], 101);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_25030085_lsu.md
Name: ysyx_25030085_lsu

Overview:
- Load/store unit that executes the decoder's MemRead/MemWrite/MemOp commands against a valid/ready memory bus.
- Performs store byte-lane steering and write-strobe generation.
- Performs load lane extraction and sign/zero extension.
- Detects misaligned and illegal accesses.
- Sits between the core's execute stage (address from ALU, data from rs2) and the data-memory bus.

Parameters:
- ADDR_W, 32, address width; bus address is word-aligned (low 2 bits forced 0).
- TIMEOUT_CYC, 255, response-wait limit (used only with LSU_TIMEOUT_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- core_valid  in  1  command request; sampled only in IDLE.
- mem_read  in  1  load command.
- mem_write  in  1  store command.
- mem_op  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu.
- addr  in  ADDR_W  effective byte address.
- wdata  in  32  store data (rs2).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  extended load result, valid while done=1.
- err  out  1  qualifies done: misaligned, illegal, bus error or timeout.
- bus_req_valid  out  1  request valid.
- bus_req_ready  in  1  request accepted.
- bus_req_addr  out  ADDR_W  {addr[ADDR_W-1:2],2'b00}.
- bus_req_we  out  1  1 = write.
- bus_req_wstrb  out  4  byte strobes.
- bus_req_wdata  out  32  lane-replicated store data.
- bus_rsp_valid  in  1  response valid (reads and writes).
- bus_rsp_ready  out  1  high only in RSP.
- bus_rsp_rdata  in  32  read word.
- bus_rsp_err  in  1  bus error.

Behaviour:
- Reset state: FSM in IDLE. All outputs are 0, including the captured addr, op and data registers.
- Reset is asynchronous and may arrive mid-operation:
  - It aborts the transaction and drops bus_req_valid immediately.
  - Any late response is ignored, because bus_rsp_ready=0 in IDLE.
- States: IDLE, REQ, RSP, DONE.
- IDLE, when core_valid and (mem_read or mem_write):
  - Capture addr, mem_op, wdata and we.
  - Legal and aligned command: go to REQ.
  - Otherwise: go to DONE with err=1 and no bus activity.
  - core_valid with neither mem_read nor mem_write is ignored.
- Illegal commands:
  - mem_read and mem_write both high.
  - mem_op 011, 110 or 111.
  - Store with mem_op 100 or 101.
- Misaligned commands:
  - h/hu/sh with addr[0]=1.
  - w/sw with addr[1:0]!=0.
- REQ:
  - bus_req_* are driven from registers.
  - bus_req_valid and all request fields stay stable until bus_req_ready.
  - On the handshake edge, go to RSP.
- RSP:
  - bus_rsp_ready=1.
  - On bus_rsp_valid, register rdata (0 for stores) and err=bus_rsp_err, then go to DONE.
  - A response arriving in the same cycle as REQ's handshake cannot occur, because ready is low in REQ.
- DONE: done=1 for exactly one cycle, then IDLE. rdata and err are 0 whenever done=0.
- Latency: accept edge T0; bus_req_valid high in T0+1; earliest response in T0+2; done in T0+3.
- Misaligned or illegal commands: done in T0+1.
- Store steering (k = addr[1:0]):
  - sb: wstrb = 0001<<k, wdata = {4{wdata[7:0]}}.
  - sh: wstrb = 0011<<k, wdata = {2{wdata[15:0]}}.
  - sw: wstrb = 1111, wdata unchanged.
  - Loads: wstrb = 0000.
- Load extract: shift the read word right by 8*k.
  - b sign-extends bit 7; bu zero-extends bit 7.
  - h sign-extends bit 15; hu zero-extends bit 15.
  - w passes the word through.
- Command inputs are ignored while busy; the core holds them until done.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - An 8+ bit counter clears on entry to RSP and increments each RSP cycle.
  - When it reaches TIMEOUT_CYC without bus_rsp_valid, go to DONE with err=1 and rdata=0.
  - A response arriving in the same cycle as the timeout wins.
- LSU_TIMEOUT_EN undefined: RSP waits indefinitely; no counter is synthesized.

Decomposition:
- Package ysyx_25030085_lsu_pkg holds:
  - MEMOP_B/H/W/BU/HU localparams.
  - The state encoding IDLE/REQ/RSP/DONE.
  - Function legal_op(op, we).
  - Function aligned(op, addr[1:0]).
- Sub-module ysyx_25030085_lsu_align (purely combinational):
  - Inputs: op, k, wdata, bus rdata.
  - Outputs: wstrb, steered wdata, extended rdata.
  - Main FSM module instantiates it once.

Test Plan:
- sb, addr=0x80000003, wdata=0x000000A5, ready immediate, rsp after 1 cycle -> bus_req_addr=0x80000000, wstrb=1000, bus_req_wdata=0xA5A5A5A5, done at T0+3, err=0, rdata=0.
- lb, addr=0x80000002, bus_rsp_rdata=0x1280FF34 -> rdata=0xFFFFFF80. Same with lbu -> rdata=0x00000080.
- lh, addr=0x80000001 -> done at T0+1 with err=1, bus_req_valid never asserted. Repeat with mem_op=011 -> err=1.
- lw, addr=0x80000010, bus_req_ready held low 5 cycles -> bus_req_valid and fields stable throughout; rsp_rdata=0xDEADBEEF with rsp_err=1 -> done, err=1.
- rst_n pulled low while in RSP, then rsp_valid arrives after release -> all outputs 0 immediately, response ignored, next lw completes normally.
- LSU_TIMEOUT_EN, TIMEOUT_CYC=4, no response -> done with err=1 exactly 4 cycles after entering RSP. Without the macro -> busy stays 1.
